// File: rtl/iob_ethoc_arb_pkg.sv
// rtl/iob_ethoc_arb_pkg.sv - shared types and constants for the two-master iob_ethoc arbiter
package iob_ethoc_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;

    // Round-robin pick between two requesters: on contention the one not
    // granted last wins, otherwise the single requester wins.
    function automatic logic rr_pick(input logic [1:0] req, input logic last);
        logic pick;
        if (req == 2'b11) begin
            pick = ~last;
        end else begin
            pick = req[1];
        end
        return pick;
    endfunction

endpackage

// File: rtl/iob_rr_arb2.sv
// rtl/iob_rr_arb2.sv - two-input round-robin grant logic with last-grant register
module iob_rr_arb2
    import iob_ethoc_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       grant_en,
    output logic       any_req,
    output logic       gnt_idx
);

    logic last_q;

    assign any_req = |req;

    // Winner for the current request pattern, relative to the previous grant
    always_comb begin
        gnt_idx = rr_pick(req, last_q);
    end

    // Last-grant history; reset to 1 so requester 0 wins the first contention
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else if (grant_en && any_req) begin
            last_q <= gnt_idx;
        end
    end

endmodule

// File: rtl/iob_ethoc_arb.sv
// rtl/iob_ethoc_arb.sv - arbitrates two IOb masters onto one iob_ethoc slave with timeout
module iob_ethoc_arb
    import iob_ethoc_arb_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter int                DATA_W   = 32,
    parameter int                TO_W     = 8,
    parameter int                TIMEOUT  = 200,
    parameter logic [DATA_W-1:0] ERR_DATA = ERR_DATA_DEFAULT
) (
    input  logic                clk_i,
    input  logic                arst_n_i,
    input  logic                m0_valid,
    input  logic [ADDR_W-1:0]   m0_address,
    input  logic [DATA_W-1:0]   m0_wdata,
    input  logic [DATA_W/8-1:0] m0_wstrb,
    output logic [DATA_W-1:0]   m0_rdata,
    output logic                m0_ready,
    input  logic                m1_valid,
    input  logic [ADDR_W-1:0]   m1_address,
    input  logic [DATA_W-1:0]   m1_wdata,
    input  logic [DATA_W/8-1:0] m1_wstrb,
    output logic [DATA_W-1:0]   m1_rdata,
    output logic                m1_ready,
    output logic                s_valid,
    output logic [ADDR_W-1:0]   s_address,
    output logic [DATA_W-1:0]   s_wdata,
    output logic [DATA_W/8-1:0] s_wstrb,
    input  logic [DATA_W-1:0]   s_rdata,
    input  logic                s_ready,
    output logic                err_o,
    output logic                err_id_o
);

    localparam int              STRB_W  = DATA_W / 8;
    localparam bit              TO_EN   = (TIMEOUT != 0);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    if (TIMEOUT >= (1 << TO_W)) begin : g_bad_timeout
        $error("TIMEOUT must be below 2**TO_W");
    end

    state_t              state_q;
    state_t              state_d;
    logic                any_req;
    logic                gnt_idx;
    logic                grant_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [STRB_W-1:0]   wstrb_q;
    logic [DATA_W-1:0]   rdata_q;
    logic [TO_W-1:0]     cnt_q;
    logic                to_flag_q;
    logic                err_id_q;
    logic                hit_to;

    iob_rr_arb2 u_rr (
        .clk      (clk_i),
        .rst_n    (arst_n_i),
        .req      ({m1_valid, m0_valid}),
        .grant_en (state_q == ST_IDLE),
        .any_req  (any_req),
        .gnt_idx  (gnt_idx)
    );

    // The slave has had its last allowed cycle and still has not answered
    assign hit_to = TO_EN && !s_ready && (cnt_q == TO_LAST);

    // Forwarded request is held in registers so it stays stable through REQ
    assign s_address = addr_q;
    assign s_wdata   = wdata_q;
    assign s_wstrb   = wstrb_q;
    assign m0_rdata  = rdata_q;
    assign m1_rdata  = rdata_q;
    assign err_id_o  = err_id_q;

    // State register
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and per-state outputs
    always_comb begin
        state_d  = state_q;
        s_valid  = 1'b0;
        m0_ready = 1'b0;
        m1_ready = 1'b0;
        err_o    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                s_valid = 1'b1;
                if (s_ready || hit_to) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                m0_ready = ~grant_q;
                m1_ready = grant_q;
                err_o    = to_flag_q;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Request latching, response capture and timeout bookkeeping
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            grant_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rdata_q   <= '0;
            cnt_q     <= '0;
            to_flag_q <= 1'b0;
            err_id_q  <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (any_req) begin
                        grant_q   <= gnt_idx;
                        addr_q    <= gnt_idx ? m1_address : m0_address;
                        wdata_q   <= gnt_idx ? m1_wdata : m0_wdata;
                        wstrb_q   <= gnt_idx ? m1_wstrb : m0_wstrb;
                        cnt_q     <= '0;
                        to_flag_q <= 1'b0;
                    end
                end
                ST_REQ: begin
                    if (s_ready) begin
                        rdata_q   <= s_rdata;
                        to_flag_q <= 1'b0;
                    end else if (hit_to) begin
                        rdata_q   <= ERR_DATA;
                        to_flag_q <= 1'b1;
                        err_id_q  <= grant_q;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iob_ethoc_arb.sv
// tb/tb_iob_ethoc_arb.sv - self-checking bench for iob_ethoc_arb across three TIMEOUT settings
module tb_iob_ethoc_arb;

    logic        clk;
    logic        rst_n;
    logic        mv   [3][2];
    logic [15:0] ma   [3][2];
    logic [31:0] mw   [3][2];
    logic [3:0]  ms   [3][2];
    logic        mr   [3][2];
    logic [31:0] mrd  [3][2];
    logic        sv   [3];
    logic [15:0] sa   [3];
    logic [31:0] swd  [3];
    logic [3:0]  sws  [3];
    logic [31:0] srd  [3];
    logic        srdy [3];
    logic        err  [3];
    logic        eid  [3];

    int vectors;
    int miscompares;

    bit pend     [3][2];
    int last_gnt [3];
    bit exp_eid  [3];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        iob_ethoc_arb #(
            .TIMEOUT (g == 0 ? 200 : (g == 1 ? 4 : 0))
        ) dut (
            .clk_i      (clk),
            .arst_n_i   (rst_n),
            .m0_valid   (mv[g][0]),
            .m0_address (ma[g][0]),
            .m0_wdata   (mw[g][0]),
            .m0_wstrb   (ms[g][0]),
            .m0_rdata   (mrd[g][0]),
            .m0_ready   (mr[g][0]),
            .m1_valid   (mv[g][1]),
            .m1_address (ma[g][1]),
            .m1_wdata   (mw[g][1]),
            .m1_wstrb   (ms[g][1]),
            .m1_rdata   (mrd[g][1]),
            .m1_ready   (mr[g][1]),
            .s_valid    (sv[g]),
            .s_address  (sa[g]),
            .s_wdata    (swd[g]),
            .s_wstrb    (sws[g]),
            .s_rdata    (srd[g]),
            .s_ready    (srdy[g]),
            .err_o      (err[g]),
            .err_id_o   (eid[g])
        );
    end

    function automatic int tmo(input int d);
        return (d == 0) ? 200 : ((d == 1) ? 4 : 0);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_all();
        for (int d = 0; d < 3; d++) begin
            for (int n = 0; n < 2; n++) begin
                mv[d][n]   = 1'b0;
                ma[d][n]   = '0;
                mw[d][n]   = '0;
                ms[d][n]   = '0;
                pend[d][n] = 1'b0;
            end
            srdy[d]     = 1'b0;
            srd[d]      = '0;
            last_gnt[d] = 1;
            exp_eid[d]  = 1'b0;
        end
    endtask

    task automatic new_req(input int d, input int n);
        mv[d][n]   = 1'b1;
        ma[d][n]   = 16'($urandom);
        mw[d][n]   = $urandom;
        ms[d][n]   = 4'($urandom);
        pend[d][n] = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clear_all();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    // One transaction from an IDLE sample point to the next IDLE sample point.
    // The reference is the transaction-level rule set: winner by round robin,
    // response after the slave delay or after TIMEOUT REQ cycles, whichever is first.
    task automatic serve(input int d, input int delay, input logic [31:0] sdata,
                         input bit late_other, output int w);
        int  t;
        bit  tmo_hit;
        int  kend;
        t = tmo(d);
        if (pend[d][0] && pend[d][1]) begin
            w = 1 - last_gnt[d];
        end else if (pend[d][1]) begin
            w = 1;
        end else begin
            w = 0;
        end
        last_gnt[d] = w;
        tmo_hit = (t != 0) && (delay >= t);
        kend = tmo_hit ? t - 1 : delay;
        tick();
        for (int k = 0; k <= kend; k++) begin
            chk("req_s_valid", 32'(sv[d]), 32'd1);
            chk("req_s_address", 32'(sa[d]), 32'(ma[d][w]));
            chk("req_s_wdata", swd[d], mw[d][w]);
            chk("req_s_wstrb", 32'(sws[d]), 32'(ms[d][w]));
            chk("req_no_ready", 32'({mr[d][1], mr[d][0]}), 32'd0);
            if (k == 0 && late_other && !pend[d][1-w]) begin
                new_req(d, 1 - w);
            end
            srdy[d] = (k == delay);
            srd[d]  = (k == delay) ? sdata : $urandom;
            tick();
        end
        srdy[d] = 1'b0;
        if (tmo_hit) begin
            exp_eid[d] = w[0];
        end
        chk("resp_ready_winner", 32'(mr[d][w]), 32'd1);
        chk("resp_ready_other", 32'(mr[d][1-w]), 32'd0);
        chk("resp_rdata", mrd[d][w], tmo_hit ? 32'hDEADBEEF : sdata);
        chk("resp_err", 32'(err[d]), 32'(tmo_hit));
        chk("resp_err_id", 32'(eid[d]), 32'(exp_eid[d]));
        chk("resp_s_valid", 32'(sv[d]), 32'd0);
        mv[d][w]   = 1'b0;
        pend[d][w] = 1'b0;
        tick();
        chk("idle_s_valid", 32'(sv[d]), 32'd0);
        chk("idle_ready", 32'({mr[d][1], mr[d][0]}), 32'd0);
        chk("idle_err", 32'(err[d]), 32'd0);
    endtask

    initial begin
        int w;
        int order [4];
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        clear_all();
        #12;
        for (int d = 0; d < 3; d++) begin
            chk("rst_s_valid", 32'(sv[d]), 32'd0);
            chk("rst_s_address", 32'(sa[d]), 32'd0);
            chk("rst_s_wdata", swd[d], 32'd0);
            chk("rst_s_wstrb", 32'(sws[d]), 32'd0);
            chk("rst_ready", 32'({mr[d][1], mr[d][0]}), 32'd0);
            chk("rst_rdata0", mrd[d][0], 32'd0);
            chk("rst_rdata1", mrd[d][1], 32'd0);
            chk("rst_err", 32'(err[d]), 32'd0);
            chk("rst_err_id", 32'(eid[d]), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Single read with minimum latency
        mv[0][0] = 1'b1; ma[0][0] = 16'h0040; mw[0][0] = 32'h0; ms[0][0] = 4'h0;
        pend[0][0] = 1'b1;
        serve(0, 0, 32'h0000A000, 1'b0, w);

        // Contention from reset: both requesters always pending
        do_reset();
        new_req(0, 0);
        new_req(0, 1);
        for (int i = 0; i < 4; i++) begin
            serve(0, 0, $urandom, 1'b0, w);
            order[i] = w;
            new_req(0, w);
        end
        chk("rr_order", {order[0][7:0], order[1][7:0], order[2][7:0], order[3][7:0]}, 32'h00010001);
        serve(0, 0, $urandom, 1'b0, w);
        serve(0, 0, $urandom, 1'b0, w);

        // Write from m1 with a slow slave
        mv[0][1] = 1'b1; ma[0][1] = 16'h0004; mw[0][1] = 32'h12345678; ms[0][1] = 4'hF;
        pend[0][1] = 1'b1;
        serve(0, 5, 32'h0, 1'b0, w);

        // Timeout on m0, then a late s_ready must change nothing
        do_reset();
        mv[1][0] = 1'b1; ma[1][0] = 16'h0100; mw[1][0] = 32'h0; ms[1][0] = 4'h0;
        pend[1][0] = 1'b1;
        serve(1, 1000, 32'h0, 1'b0, w);
        srdy[1] = 1'b1;
        srd[1]  = 32'h0BAD0BAD;
        tick();
        srdy[1] = 1'b0;
        chk("late_s_valid", 32'(sv[1]), 32'd0);
        chk("late_ready", 32'({mr[1][1], mr[1][0]}), 32'd0);
        chk("late_err", 32'(err[1]), 32'd0);
        chk("late_err_id", 32'(eid[1]), 32'd0);
        tick();
        chk("late_idle", 32'({sv[1], mr[1][1], mr[1][0]}), 32'd0);

        // Timeout on m1 sets err_id; a response exactly on the last cycle is not a timeout
        new_req(1, 1);
        serve(1, 1000, 32'h0, 1'b0, w);
        new_req(1, 0);
        serve(1, 3, 32'hC0DE0003, 1'b0, w);
        chk("err_id_sticky", 32'(eid[1]), 32'd1);

        // Reset in the middle of a request
        new_req(0, 0);
        tick();
        chk("mid_s_valid", 32'(sv[0]), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_s_valid", 32'(sv[0]), 32'd0);
        chk("abort_ready", 32'({mr[0][1], mr[0][0]}), 32'd0);
        clear_all();
        tick();
        chk("abort_hold", 32'({sv[0], mr[0][1], mr[0][0]}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("abort_after", 32'({sv[0], mr[0][1], mr[0][0]}), 32'd0);
        new_req(0, 0);
        new_req(0, 1);
        serve(0, 1, $urandom, 1'b0, w);
        chk("post_reset_first_mr0", 32'(mr[0][0]), 32'd0);
        serve(0, 0, $urandom, 1'b0, w);

        // Timeout disabled, very slow slave
        mv[2][0] = 1'b1; ma[2][0] = 16'h0200; mw[2][0] = 32'h0; ms[2][0] = 4'h0;
        pend[2][0] = 1'b1;
        serve(2, 300, 32'h5A5A0001, 1'b0, w);

        // Randomized traffic against the TIMEOUT=4 instance
        for (int i = 0; i < 60; i++) begin
            if (!pend[1][0] && $urandom_range(0, 1) == 1) new_req(1, 0);
            if (!pend[1][1] && $urandom_range(0, 1) == 1) new_req(1, 1);
            if (!pend[1][0] && !pend[1][1]) new_req(1, $urandom_range(0, 1));
            serve(1, $urandom_range(0, 6), $urandom, 1'($urandom_range(0, 1)), w);
        end
        for (int i = 0; i < 2; i++) begin
            if (pend[1][0] || pend[1][1]) begin
                serve(1, $urandom_range(0, 6), $urandom, 1'b0, w);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
